axil_arbiter_rr_rd: RTL and testbench

- Round-robin arbiter for the read path of the AXI-Lite interconnect.
- Shares one slave read channel (AR/R) between NUMBER_MASTER masters.
- Each grant is held from arbitration until the R-channel handshake of the granted master completes.
- Fairness: the most recently served master gets the lowest priority in the next arbitration, so no requester starves.

---
 rtl/axil_arbiter_rr_rd.sv | 132 +++++++++++++
 tb/tb_axil_arbiter_rr_rd.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axil_arbiter_rr_rd.sv
// Round-robin arbiter for the AXI-Lite read path.
// Shares one slave read channel (AR/R) between NUMBER_MASTER masters. A grant
// is held from arbitration until the granted master's R handshake completes.
// The most recently served master has the lowest priority in the next search.
//
// State table:
//   IDLE | no grant; waits for any request
//   ARB  | searches requests for the next master after last_grant
//   BUSY | grant held until s_axil_rvalid && m_axil_rready[grant_rd]
//
// Ports:
//   aclk           clock, rising edge
//   aresetn        synchronous active-low reset
//   request_rd     per-master pending read (arvalid)
//   grant_rd       index of granted master, 0 when no grant
//   grant_valid    grant_rd selects the current owner
//   s_axil_rvalid  rvalid from the shared slave
//   m_axil_rready  rready from each master
module axil_arbiter_rr_rd #(
  parameter int NUMBER_MASTER = 2,
  parameter int GW            = $clog2(NUMBER_MASTER)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NUMBER_MASTER-1:0] request_rd,
  output logic [GW-1:0]            grant_rd,
  output logic                     grant_valid,
  input  logic                     s_axil_rvalid,
  input  logic [NUMBER_MASTER-1:0] m_axil_rready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    BUSY = 2'd2
  } state_t;

  localparam logic [GW-1:0] LAST_RST = GW'(NUMBER_MASTER - 1);

  state_t        state;
  state_t        state_nxt;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] last_grant_nxt;
  logic [GW-1:0] grant_nxt;
  logic          valid_nxt;

  logic          found_hi;
  logic          found_lo;
  logic [GW-1:0] pick_hi;
  logic [GW-1:0] pick_lo;
  logic [GW-1:0] pick;
  logic          found;
  logic          done;

  // Round-robin search without a modulo: the first requester above
  // last_grant wins; failing that, the first requester at or below it.
  // Only indices < NUMBER_MASTER are ever visited, so non-power-of-2
  // counts never produce an out-of-range grant.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int j = 0; j < NUMBER_MASTER; j++) begin
      if (request_rd[j]) begin
        if (j > int'(last_grant)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            pick_hi  = GW'(j);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          pick_lo  = GW'(j);
        end
      end
    end
    found = found_hi | found_lo;
    pick  = found_hi ? pick_hi : pick_lo;
  end

  // Only the owner's rready can complete the transfer.
  assign done = s_axil_rvalid && m_axil_rready[grant_rd];

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_rd;
    valid_nxt      = grant_valid;
    last_grant_nxt = last_grant;
    unique case (state)
      IDLE: begin
        if (|request_rd) state_nxt = ARB;
      end
      ARB: begin
        if (found) begin
          grant_nxt = pick;
          valid_nxt = 1'b1;
          state_nxt = BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (done) begin
          last_grant_nxt = grant_rd;
          grant_nxt      = '0;
          valid_nxt      = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: begin
        grant_nxt = '0;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      grant_rd    <= '0;
      grant_valid <= 1'b0;
      last_grant  <= LAST_RST;
    end else begin
      state       <= state_nxt;
      grant_rd    <= grant_nxt;
      grant_valid <= valid_nxt;
      last_grant  <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_axil_arbiter_rr_rd.sv
// Bench for axil_arbiter_rr_rd: a 4-master instance driven by a per-cycle
// vector table with expected outputs queued as each vector is applied, and a
// 3-master instance exercising wrap/skip with a bounded hand-written sequence.
module tb_axil_arbiter_rr_rd;

  logic       aclk;
  logic       aresetn;
  logic [3:0] req4;
  logic       rvalid4;
  logic [3:0] rready4;
  logic [1:0] gr4;
  logic       gv4;
  logic [2:0] req3;
  logic       rvalid3;
  logic [2:0] rready3;
  logic [1:0] gr3;
  logic       gv3;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon3     = 1'b0;

  axil_arbiter_rr_rd #(.NUMBER_MASTER(4)) u4 (
    .aclk(aclk), .aresetn(aresetn), .request_rd(req4), .grant_rd(gr4),
    .grant_valid(gv4), .s_axil_rvalid(rvalid4), .m_axil_rready(rready4)
  );

  axil_arbiter_rr_rd #(.NUMBER_MASTER(3)) u3 (
    .aclk(aclk), .aresetn(aresetn), .request_rd(req3), .grant_rd(gr3),
    .grant_valid(gv3), .s_axil_rvalid(rvalid3), .m_axil_rready(rready3)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rvalid;
    logic [3:0] rready;
    logic       exp_gv;
    logic [1:0] exp_gr;
  } vec_t;

  typedef struct {
    int         idx;
    logic       gv;
    logic [1:0] gr;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   exp3[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic v,
                     input logic [3:0] rr, input logic egv, input logic [1:0] egr);
    vec_t t;
    t.rst_n = r; t.req = q; t.rvalid = v; t.rready = rr;
    t.exp_gv = egv; t.exp_gr = egr;
    vecs.push_back(t);
  endtask

  // Outputs after each edge are compared against the expectation queued
  // when that cycle's inputs were applied.
  always @(posedge aclk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("v%0d_grant_valid", e.idx), int'(gv4), int'(e.gv));
      check($sformatf("v%0d_grant_rd", e.idx), int'(gr4), int'(e.gr));
    end
  end

  // 3-master instance: only masters 0 and 2 request, so index 1 or 3 is
  // never legal, and an idle grant must read 0.
  always @(negedge aclk) begin
    if (mon3) begin
      check("u3_index_legal", int'((gr3 == 2'd0) || (gv3 && gr3 == 2'd2)), 1);
    end
  end

  initial begin
    exp_t e;
    aresetn = 1'b0; req4 = '0; rvalid4 = 1'b0; rready4 = '0;
    req3 = '0; rvalid3 = 1'b0; rready3 = '0;

    // reset held 3 cycles with all requesting
    add(0, 4'b1111, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 0, 0);
    add(0, 4'b1111, 0, 4'b0000, 0, 0);
    // round robin 0,1,2,3,0 with completion one cycle after each grant;
    // completions overlap held requests, so each release returns to IDLE
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 1, 0);
    add(1, 4'b1111, 1, 4'b0001, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 1, 1);
    add(1, 4'b1111, 1, 4'b0010, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 1, 2);
    add(1, 4'b1111, 1, 4'b0100, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 1, 3);
    add(1, 4'b1111, 1, 4'b1000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 1, 0);
    add(1, 4'b1111, 1, 4'b1111, 0, 0);
    // hold until owner handshake: grant 1, drop its request,
    // foreign rready / rready without rvalid do not release
    add(1, 4'b0010, 0, 4'b0000, 0, 0);
    add(1, 4'b0010, 0, 4'b0000, 1, 1);
    add(1, 4'b0000, 1, 4'b0001, 1, 1);
    add(1, 4'b0000, 1, 4'b1101, 1, 1);
    add(1, 4'b0000, 0, 4'b0010, 1, 1);
    add(1, 4'b0000, 1, 4'b0010, 0, 0);
    // withdrawal in ARB leaves last_grant at 1
    add(1, 4'b0100, 0, 4'b0000, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 0);
    // search uses the current-cycle request: 0101 from last=1 picks 2
    add(1, 4'b1000, 0, 4'b0000, 0, 0);
    add(1, 4'b0101, 0, 4'b0000, 1, 2);
    // release plus new requests same cycle: back to IDLE first
    add(1, 4'b1111, 1, 4'b0100, 0, 0);
    add(1, 4'b0100, 0, 4'b0000, 0, 0);
    add(1, 4'b0100, 0, 4'b0000, 1, 2);
    // mid-transfer reset while owner is 2, then restart from master 0
    add(0, 4'b1111, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0000, 1, 0);
    // single requester re-granted
    add(1, 4'b0001, 1, 4'b0001, 0, 0);
    add(1, 4'b0001, 0, 4'b0000, 0, 0);
    add(1, 4'b0001, 0, 4'b0000, 1, 0);
    add(1, 4'b0000, 1, 4'b0001, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge aclk);
      aresetn = vecs[i].rst_n;
      req4    = vecs[i].req;
      rvalid4 = vecs[i].rvalid;
      rready4 = vecs[i].rready;
      e.idx = i; e.gv = vecs[i].exp_gv; e.gr = vecs[i].exp_gr;
      sb.push_back(e);
    end
    @(negedge aclk);
    req4 = '0; rvalid4 = 1'b0; rready4 = '0;
    check("sb_drained", sb.size(), 0);

    // 3 masters, 0 and 2 requesting: grants alternate 0,2,0,2
    exp3.push_back(0); exp3.push_back(2); exp3.push_back(0); exp3.push_back(2);
    mon3 = 1'b1;
    req3 = 3'b101;
    for (int g = 0; g < 4; g++) begin
      int exp_idx;
      for (int c = 0; c < 10 && !gv3; c++) @(negedge aclk);
      exp_idx = exp3.pop_front();
      if (!gv3) begin
        check($sformatf("u3_grant%0d_timeout", g), 0, 1);
      end else begin
        check($sformatf("u3_grant%0d", g), int'(gr3), exp_idx);
        rvalid3 = 1'b1; rready3 = 3'b111;
        @(negedge aclk);
        rvalid3 = 1'b0; rready3 = '0;
        check($sformatf("u3_release%0d", g), int'(gv3), 0);
      end
    end
    req3 = '0;
    repeat (3) @(negedge aclk);
    mon3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
